// File: rtl/rv_pkg.sv
// Shared definitions for the instruction-fetch slice: default NOP word and
// the fetch/load controller state encoding.
package rv_pkg;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_LOAD  = 2'd2
  } state_t;

endpackage

// File: rtl/rv_dpram.sv
// Simple dual-port word RAM: port A writes, port B registered reads with a
// read enable so the output holds while the reader stalls. Contents are
// never cleared by reset.
module rv_dpram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_wea,
  input  logic [AW-1:0]    i_addra,
  input  logic [WIDTH-1:0] i_dina,
  input  logic             i_renb,
  input  logic [AW-1:0]    i_addrb,
  output logic [WIDTH-1:0] o_doutb
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_doutb;

  // Port A: write path used by the boot loader
  always_ff @(posedge clk) begin
    if (i_wea) r_mem[i_addra] <= i_dina;
  end

  // Port B: read path, only updates on an enabled read
  always_ff @(posedge clk) begin
    if (i_renb) r_doutb <= r_mem[i_addrb];
  end

  assign o_doutb = r_doutb;

endmodule

// File: rtl/rv_imem_fetch.sv
// Instruction memory with a req/rdy fetch port (1-cycle latency, held under
// stall) and an auto-incrementing boot-load port. Fetches are blocked while
// the loader owns the RAM, so the two ports never touch it together.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  S_RUN   | normal fetching; loader writes ignored
//  S_DRAIN | load requested, waiting for presented instruction to leave
//  S_LOAD  | loader owns the RAM; writes land at the pointer
module rv_imem_fetch #(
  parameter int                XLEN      = 32,
  parameter int                ILEN      = 32,
  parameter int                DEPTH     = 1024,
  parameter int                AW        = $clog2(DEPTH),
  parameter logic [XLEN-1:0]   BASE_ADDR = '0,
  parameter logic [ILEN-1:0]   NOP_INSTR = ILEN'(rv_pkg::NOP_INSTR)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_req_i,
  input  logic [XLEN-1:0] fetch_addr_i,
  output logic            fetch_rdy_o,
  input  logic            flush_i,
  output logic            instr_vld_o,
  input  logic            instr_ack_i,
  output logic [ILEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  output logic            instr_err_o,
  input  logic            load_start_i,
  input  logic [AW-1:0]   load_addr_i,
  input  logic            load_we_i,
  input  logic [ILEN-1:0] load_data_i,
  input  logic            load_done_i,
  output logic            load_busy_o,
  output logic [AW-1:0]   load_ptr_o
);

  import rv_pkg::*;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_vld;
  logic            r_err;
  logic [XLEN-1:0] r_pc;
  logic [AW-1:0]   r_ptr;

  logic [XLEN-1:0] w_off;
  logic [XLEN-1:0] w_idx_full;
  logic            w_oor;
  logic            w_mis;
  logic            w_ferr;
  logic            w_rdy;
  logic            w_acc;
  logic            w_renb;
  logic            w_wea;
  logic            w_leave;
  logic [ILEN-1:0] w_doutb;

  // Range check works on the full-width offset so addresses far beyond the
  // RAM are not aliased back into it by truncation.
  assign w_off      = fetch_addr_i - BASE_ADDR;
  assign w_idx_full = w_off >> 2;
  assign w_oor      = (fetch_addr_i < BASE_ADDR) | (w_idx_full >= XLEN'(DEPTH));
  assign w_mis      = (fetch_addr_i[1:0] != 2'b00);
  assign w_ferr     = w_mis | w_oor;

  assign w_rdy   = (r_state == S_RUN) & ~load_start_i & ~flush_i & (~r_vld | instr_ack_i);
  assign w_acc   = fetch_req_i & w_rdy;
  // An erroring fetch never reads the RAM
  assign w_renb  = w_acc & ~w_ferr;
  // The load_start_i cycle only re-latches the pointer; its write is dropped
  assign w_wea   = (r_state == S_LOAD) & load_we_i & ~load_start_i;
  // Presented instruction is gone (or leaves this cycle)
  assign w_leave = ~r_vld | instr_ack_i | flush_i;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; a new load_start_i in S_LOAD keeps loading
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN: begin
        if (load_start_i) w_state_nxt = w_leave ? S_LOAD : S_DRAIN;
      end
      S_DRAIN: begin
        if (w_leave) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (load_done_i && !load_start_i) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  // Presented-instruction slot: load on accept, clear on ack/flush, else hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= 1'b0;
      r_err <= 1'b0;
      r_pc  <= '0;
    end else if (w_acc) begin
      r_vld <= 1'b1;
      r_err <= w_ferr;
      r_pc  <= fetch_addr_i;
    end else if (instr_ack_i || flush_i) begin
      r_vld <= 1'b0;
    end
  end

  // Load pointer: latch on start, post-increment on each accepted write
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_ptr <= '0;
    else if (load_start_i) r_ptr <= load_addr_i;
    else if (w_wea)       r_ptr <= r_ptr + 1'b1;
  end

  rv_dpram #(
    .WIDTH (ILEN),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_wea   (w_wea),
    .i_addra (r_ptr),
    .i_dina  (load_data_i),
    .i_renb  (w_renb),
    .i_addrb (w_idx_full[AW-1:0]),
    .o_doutb (w_doutb)
  );

  assign fetch_rdy_o = w_rdy;
  assign instr_vld_o = r_vld;
  assign instr_err_o = r_err;
  assign instr_pc_o  = r_pc;
  assign instr_o     = (r_vld & ~r_err) ? w_doutb : NOP_INSTR;
  assign load_busy_o = (r_state != S_RUN);
  assign load_ptr_o  = r_ptr;

endmodule
